uart_tx_arb: RTL and testbench

- Round-robin arbiter that shares one uart_tx transmitter among N_SRC byte sources. Each source is a first-word-fall-through FIFO.
- Toward uart_tx it looks like a single read FIFO: it drives tx_empty and tx_data, and accepts the tx_rd_en pulse.
- On each grant it can prepend a source-ID header byte. It holds the grant for up to BURST_LEN data bytes, then waits for the final frame's tx_done before re-arbitrating.

---
 rtl/uart_tx_arb.sv | 131 +++++++++++++
 tb/tb_uart_tx_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter that lets N_SRC first-word-fall-through byte
// sources share one uart_tx. Toward uart_tx it looks like a single read FIFO.
// Each grant can send a source-ID header byte first. The grant then carries up
// to BURST_LEN data bytes and waits for the last frame's tx_done before
// re-arbitrating.
module uart_tx_arb #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned BURST_LEN = 16,
  parameter bit          HDR_EN    = 1'b1,
  parameter logic [3:0]  HDR_MARK  = 4'hA
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst,
  input  logic [N_SRC-1:0]           src_empty,
  input  logic [N_SRC*D_WIDTH-1:0]   src_rd_data,
  output logic [N_SRC-1:0]           src_rd_en,
  output logic                       tx_empty,
  input  logic                       tx_rd_en,
  output logic [D_WIDTH-1:0]         tx_data,
  input  logic                       tx_done,
  output logic                       grant_vld,
  output logic [3:0]                 grant_id,
  output logic                       busy
);

  localparam int unsigned IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {IDLE, HDR, DATA, WAIT_DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   gid_q, gid_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]         burst_cnt_q, burst_cnt_d;
  logic [D_WIDTH-1:0] tx_data_q, tx_data_d;

  logic [D_WIDTH-1:0] src_byte [N_SRC];
  logic [IDX_W-1:0]   pick, cand;
  logic               found;
  logic [7:0]         hdr_byte;

  // Split the flat source data bus into one byte per source.
  always_comb begin
    for (int unsigned i = 0; i < N_SRC; i++) begin
      src_byte[i] = src_rd_data[i*D_WIDTH +: D_WIDTH];
    end
  end

  // Round-robin search: first non-empty source after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = IDX_W'((32'(rr_ptr_q) + k) % N_SRC);
      if (!found && !src_empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  assign hdr_byte = {HDR_MARK, grant_id};

  // Next-state logic and the virtual-FIFO handshake toward uart_tx.
  always_comb begin
    state_d     = state_q;
    gid_d       = gid_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    tx_data_d   = tx_data_q;
    src_rd_en   = '0;
    tx_empty    = 1'b1;
    case (state_q)
      IDLE: begin
        if (found) begin
          gid_d       = pick;
          rr_ptr_d    = pick;
          burst_cnt_d = '0;
          if (HDR_EN) state_d = HDR;
          else        state_d = DATA;
        end
      end
      HDR: begin
        tx_empty = 1'b0;
        if (tx_rd_en) begin
          tx_data_d = D_WIDTH'(hdr_byte);
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_empty = src_empty[gid_q];
        if (tx_rd_en && !src_empty[gid_q]) begin
          tx_data_d        = src_byte[gid_q];
          src_rd_en[gid_q] = 1'b1;
          burst_cnt_d      = burst_cnt_q + 8'd1;
          if (burst_cnt_d == 8'(BURST_LEN)) state_d = WAIT_DONE;
        end else if (src_empty[gid_q]) begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      gid_q       <= '0;
      rr_ptr_q    <= IDX_W'(N_SRC - 1);
      burst_cnt_q <= '0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      gid_q       <= gid_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign grant_id  = 4'(gid_q);
  assign grant_vld = (state_q != IDLE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: queue-based source FIFOs and a uart_tx model drive
// the DUT. Expected line bytes and grant IDs go into scoreboard queues that a
// monitor inside the environment process pops and compares.
module tb_uart_tx_arb;
  localparam int unsigned NS    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned FRAME = 6;
  localparam int          LIMIT = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: header enabled, BURST_LEN=4
  logic              rst;
  logic [NS-1:0]     src_empty;
  logic [NS*DW-1:0]  src_rd_data;
  logic [NS-1:0]     src_rd_en;
  logic              tx_empty, tx_rd_en, tx_done, grant_vld, busy;
  logic [DW-1:0]     tx_data;
  logic [3:0]        grant_id;

  uart_tx_arb #(.N_SRC(4), .D_WIDTH(8), .BURST_LEN(4), .HDR_EN(1'b1), .HDR_MARK(4'hA)) dut (
    .sys_clk(clk), .sys_rst(rst), .src_empty(src_empty), .src_rd_data(src_rd_data),
    .src_rd_en(src_rd_en), .tx_empty(tx_empty), .tx_rd_en(tx_rd_en), .tx_data(tx_data),
    .tx_done(tx_done), .grant_vld(grant_vld), .grant_id(grant_id), .busy(busy));

  // DUT B: header disabled
  logic              b_rst;
  logic [NS-1:0]     b_src_empty;
  logic [NS*DW-1:0]  b_src_rd_data;
  logic [NS-1:0]     b_src_rd_en;
  logic              b_tx_empty, b_tx_rd_en, b_tx_done, b_grant_vld, b_busy;
  logic [DW-1:0]     b_tx_data;
  logic [3:0]        b_grant_id;

  uart_tx_arb #(.N_SRC(4), .D_WIDTH(8), .BURST_LEN(16), .HDR_EN(1'b0), .HDR_MARK(4'hA)) dut_b (
    .sys_clk(clk), .sys_rst(b_rst), .src_empty(b_src_empty), .src_rd_data(b_src_rd_data),
    .src_rd_en(b_src_rd_en), .tx_empty(b_tx_empty), .tx_rd_en(b_tx_rd_en), .tx_data(b_tx_data),
    .tx_done(b_tx_done), .grant_vld(b_grant_vld), .grant_id(b_grant_id), .busy(b_busy));

  logic [7:0] srcq [NS][$];
  logic [7:0] exp_byte [$];
  logic [3:0] exp_grant [$];
  int  pop_cnt [NS];
  int  cyc, line_cnt, last_done_cyc, last_fall_cyc;
  int  total, bad;
  bit  force_rd, force_done, uart_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Environment: source FIFOs, uart_tx model, byte/grant/pop monitors.
  initial begin
    int fcnt;
    bit cap, prev_gv;
    logic [7:0] eb;
    logic [3:0] eg;
    fcnt = 0; cap = 0; prev_gv = 0; uart_busy = 0;
    src_empty = '1; src_rd_data = '0; tx_rd_en = 0; tx_done = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin uart_busy = 0; cap = 0; end
      if (cap) begin
        cap = 0;
        line_cnt++;
        if (exp_byte.size() == 0) begin
          total++; bad++;
          $display("FAIL byte: got %02h expected nothing", tx_data);
        end else begin
          eb = exp_byte.pop_front();
          check("byte", tx_data, eb);
        end
      end
      if (grant_vld && !prev_gv) begin
        if (exp_grant.size() == 0) begin
          total++; bad++;
          $display("FAIL grant: got %0d expected nothing", grant_id);
        end else begin
          eg = exp_grant.pop_front();
          check("grant", grant_id, eg);
        end
      end
      if (!grant_vld && prev_gv) last_fall_cyc = cyc;
      prev_gv = grant_vld;
      tx_rd_en = 0; tx_done = 0;
      for (int i = 0; i < NS; i++) begin
        src_empty[i] = (srcq[i].size() == 0);
        src_rd_data[i*DW +: DW] = (srcq[i].size() == 0) ? 8'h00 : srcq[i][0];
      end
      #1;
      if (uart_busy) begin
        fcnt--;
        if (fcnt == 0) begin tx_done = 1; uart_busy = 0; last_done_cyc = cyc; end
      end else if (!tx_empty && !rst) begin
        tx_rd_en = 1; uart_busy = 1; fcnt = FRAME; cap = 1;
      end
      if (force_rd)   begin tx_rd_en = 1; force_rd = 0; end
      if (force_done) begin tx_done = 1; force_done = 0; end
      #1;
      for (int i = 0; i < NS; i++) begin
        if (src_rd_en[i]) begin
          check("pop_gid", i, grant_id);
          if (srcq[i].size() == 0) begin
            total++; bad++;
            $display("FAIL pop_empty: src %0d popped while empty", i);
          end else begin
            void'(srcq[i].pop_front());
          end
          pop_cnt[i]++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0; step();
    for (int i = 0; i < NS; i++) pop_cnt[i] = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_byte.size() != 0 || exp_grant.size() != 0 || busy || uart_busy) && n < LIMIT) begin
      step(); n++;
    end
    check({name, "_timeout"}, 32'(n >= LIMIT), 0);
  endtask

  task automatic wait_line(input string name, input int target);
    int n = 0;
    while (line_cnt < target && n < LIMIT) begin step(); n++; end
    check({name, "_timeout"}, 32'(n >= LIMIT), 0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_tx_empty"}, tx_empty, 1);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_grant_vld"}, grant_vld, 0);
    check({tag, "_grant_id"}, grant_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_src_rd_en"}, src_rd_en, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    total = 0; bad = 0; cyc = 0; line_cnt = 0;
    force_rd = 0; force_done = 0;
    b_rst = 1; b_src_empty = '1; b_src_rd_data = 32'h5A00_0000; b_tx_rd_en = 0; b_tx_done = 0;
    rst = 1;
    step(); step(); step();
    chk_reset("rst");
    rst = 0; step();

    // Single source with header: line A0 11 22 33, three pops, grant_vld falls after last done
    srcq[0].push_back(8'h11); srcq[0].push_back(8'h22); srcq[0].push_back(8'h33);
    exp_byte.push_back(8'hA0); exp_byte.push_back(8'h11);
    exp_byte.push_back(8'h22); exp_byte.push_back(8'h33);
    exp_grant.push_back(4'd0);
    wait_done("t1");
    step();
    check("t1_pops0", pop_cnt[0], 3);
    check("t1_pops_other", pop_cnt[1] + pop_cnt[2] + pop_cnt[3], 0);
    check("t1_fall", last_fall_cyc, last_done_cyc + 1);

    // Round robin over all four sources, two bytes each
    do_reset();
    srcq[0].push_back(8'h01); srcq[0].push_back(8'h02);
    srcq[1].push_back(8'h11); srcq[1].push_back(8'h12);
    srcq[2].push_back(8'h21); srcq[2].push_back(8'h22);
    srcq[3].push_back(8'h31); srcq[3].push_back(8'h32);
    exp_byte = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12,
                 8'hA2, 8'h21, 8'h22, 8'hA3, 8'h31, 8'h32};
    exp_grant = '{4'd0, 4'd1, 4'd2, 4'd3};
    wait_done("t2");
    for (int i = 0; i < NS; i++) check("t2_pops", pop_cnt[i], 2);

    // Burst limit 4 with rr_ptr wrap back to src1
    do_reset();
    for (int i = 0; i < 6; i++) srcq[1].push_back(8'h61 + 8'(i));
    srcq[2].push_back(8'h70);
    exp_byte = '{8'hA1, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA2, 8'h70, 8'hA1, 8'h65, 8'h66};
    exp_grant = '{4'd1, 4'd2, 4'd1};
    wait_done("t3");
    check("t3_pops1", pop_cnt[1], 6);
    check("t3_pops2", pop_cnt[2], 1);

    // Protocol edges: forced read in IDLE, spurious done in DATA, forced read in WAIT_DONE
    for (int i = 0; i < NS; i++) pop_cnt[i] = 0;
    base = line_cnt;
    srcq[0].push_back(8'h99);
    exp_byte = '{8'hA0, 8'h99, 8'hA0, 8'h55};
    exp_grant = '{4'd0, 4'd0};
    force_rd = 1;
    step();
    check("t4_idle_data", tx_data, 8'h66);
    check("t4_idle_pop", pop_cnt[0], 0);
    wait_line("t4_hdr", base + 1);
    force_done = 1;
    step();
    check("t4_spur_empty", tx_empty, 0);
    check("t4_spur_gvld", grant_vld, 1);
    wait_line("t4_d1", base + 2);
    srcq[0].push_back(8'h55);
    force_rd = 1;
    step();
    check("t4_wait_pop", pop_cnt[0], 1);
    check("t4_wait_data", tx_data, 8'h99);
    wait_done("t4");
    check("t4_pops0", pop_cnt[0], 2);

    // Reset during the second data frame; restart at src0 ahead of src1
    do_reset();
    base = line_cnt;
    srcq[0].push_back(8'h31); srcq[0].push_back(8'h32); srcq[0].push_back(8'h33);
    exp_byte = '{8'hA0, 8'h31, 8'h32};
    exp_grant = '{4'd0};
    wait_line("t5_d2", base + 3);
    rst = 1;
    step();
    chk_reset("t5");
    srcq[1].push_back(8'h44);
    step();
    exp_byte = '{8'hA0, 8'h33, 8'hA1, 8'h44};
    exp_grant = '{4'd0, 4'd1};
    rst = 0;
    wait_done("t5");
    check("t5_pops0", pop_cnt[0], 3);
    check("t5_pops1", pop_cnt[1], 1);

    // Header disabled: IDLE -> DATA -> WAIT_DONE -> IDLE with a single 5A
    b_rst = 0; step();
    check("b_idle_busy", b_busy, 0);
    b_src_empty = 4'b0111;
    step();
    check("b_gvld", b_grant_vld, 1);
    check("b_gid", b_grant_id, 3);
    check("b_data_empty", b_tx_empty, 0);
    b_tx_rd_en = 1;
    #1;
    check("b_pop", b_src_rd_en, 4'b1000);
    step();
    b_tx_rd_en = 0;
    b_src_empty = '1;
    check("b_tx_data", b_tx_data, 8'h5A);
    step();
    check("b_wait_empty", b_tx_empty, 1);
    check("b_wait_gvld", b_grant_vld, 1);
    b_tx_done = 1;
    step();
    b_tx_done = 0;
    check("b_end_busy", b_busy, 0);
    check("b_end_gvld", b_grant_vld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
